// File: rtl/note_history_display_pkg.sv
// note_history_display_pkg: character codes, note and FSM types shared by the note history display.
package note_history_display_pkg;

    localparam logic [5:0] CHAR_A     = 6'd1;
    localparam logic [5:0] CHAR_B     = 6'd2;
    localparam logic [5:0] CHAR_C     = 6'd3;
    localparam logic [5:0] CHAR_D     = 6'd4;
    localparam logic [5:0] CHAR_E     = 6'd5;
    localparam logic [5:0] CHAR_F     = 6'd6;
    localparam logic [5:0] CHAR_G     = 6'd7;
    localparam logic [5:0] CHAR_N     = 6'd14;
    localparam logic [5:0] CHAR_O     = 6'd15;
    localparam logic [5:0] CHAR_S     = 6'd19;
    localparam logic [5:0] CHAR_T     = 6'd20;
    localparam logic [5:0] CHAR_SPACE = 6'd32;
    localparam logic [5:0] CHAR_0     = 6'd48;

    typedef enum logic [2:0] {NOTE_C, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A, NOTE_B} letter_e;

    typedef struct packed {
        logic       valid;
        letter_e    letter;
        logic [3:0] octave;
    } note_t;

    typedef enum logic [1:0] {INIT_LABEL, INIT_CLEAR, IDLE, DRAW} state_e;

    function automatic logic [5:0] letter_char(letter_e l);
        case (l)
            NOTE_C:  return CHAR_C;
            NOTE_D:  return CHAR_D;
            NOTE_E:  return CHAR_E;
            NOTE_F:  return CHAR_F;
            NOTE_G:  return CHAR_G;
            NOTE_A:  return CHAR_A;
            default: return CHAR_B;
        endcase
    endfunction

    function automatic logic [5:0] label_char(logic [4:0] idx);
        case (idx)
            5'd0:    return CHAR_N;
            5'd1:    return CHAR_O;
            5'd2:    return CHAR_T;
            5'd3:    return CHAR_E;
            default: return CHAR_S;
        endcase
    endfunction

endpackage

// File: rtl/note_history_display_decoder.sv
// note_decoder: combinational PS/2 set-2 make-code to note decode.
//   key_stroke : scan-code byte
//   mapped     : byte is one of the eight note keys
//   letter     : note letter index
//   octave     : octave number
module note_decoder
    import note_history_display_pkg::*;
(
    input  logic [7:0] key_stroke,
    output logic       mapped,
    output letter_e    letter,
    output logic [3:0] octave
);

    always_comb begin
        mapped = 1'b1;
        letter = NOTE_C;
        octave = 4'd4;
        case (key_stroke)
            8'h1C:   letter = NOTE_C;
            8'h1B:   letter = NOTE_D;
            8'h23:   letter = NOTE_E;
            8'h2B:   letter = NOTE_F;
            8'h34:   letter = NOTE_G;
            8'h33:   letter = NOTE_A;
            8'h3B:   letter = NOTE_B;
            8'h42:   octave = 4'd5;
            default: mapped = 1'b0;
        endcase
    end

endmodule

// File: rtl/note_history_display.sv
// note_history_display: keeps the last HIST_DEPTH played notes and redraws them on a character terminal.
//   clk, rst_n            : clock, async active-low reset
//   key_stroke, key_valid : PS/2 scan-code byte and its strobe
//   term_h/v/char/w_en    : registered terminal write request
//   term_w_ready          : terminal accepts the current write
//   busy                  : initialising or drawing
//   drop_count            : saturating count of notes lost while the pending slot was full
module note_history_display
    import note_history_display_pkg::*;
#(
    parameter int HIST_DEPTH = 4,
    parameter int ORIGIN_H   = 30,
    parameter int ORIGIN_V   = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_stroke,
    input  logic       key_valid,
    output logic [7:0] term_h,
    output logic [7:0] term_v,
    output logic [5:0] term_char,
    output logic       term_w_en,
    input  logic       term_w_ready,
    output logic       busy,
    output logic [7:0] drop_count
);

    state_e     state_q, state_d;
    logic [4:0] ptr_q, ptr_d;
    note_t      hist_q [HIST_DEPTH];
    note_t      hist_d [HIST_DEPTH];
    note_t      pend_q, pend_d;
    logic       brk_q, brk_d;
    logic [7:0] drop_q, drop_d;
    logic       en_q;
    logic [7:0] h_q, v_q, h_d;
    logic [5:0] c_q, c_d;

    logic       dec_mapped;
    letter_e    dec_letter;
    logic [3:0] dec_octave;
    note_t      key_note, push_note, sn;
    logic       complete, done, accept, push;
    logic [4:0] len;
    int         slot;

    note_decoder u_dec (
        .key_stroke(key_stroke),
        .mapped    (dec_mapped),
        .letter    (dec_letter),
        .octave    (dec_octave)
    );

    always_comb begin
        complete  = en_q & term_w_ready;
        len       = state_q == INIT_LABEL ? 5'd5 :
                    state_q == INIT_CLEAR ? 5'(3 * HIST_DEPTH - 1) : 5'(2 * HIST_DEPTH);
        done      = complete && ptr_q == len - 5'd1;
        key_note  = '{valid: 1'b1, letter: dec_letter, octave: dec_octave};
        accept    = key_valid & ~brk_q & dec_mapped;
        // The byte following F0 is a break code: swallow it and disarm.
        brk_d     = key_valid ? (~brk_q & (key_stroke == 8'hF0)) : brk_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        hist_d    = hist_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_note = key_note;
        if (state_q == IDLE) begin
            push = accept;
        end else if (done && state_q != INIT_LABEL) begin
            // Leaving for IDLE frees the pending slot, so a key arriving now is never dropped.
            if (pend_q.valid) begin
                push      = 1'b1;
                push_note = pend_q;
                pend_d    = accept ? key_note : '0;
            end else begin
                push = accept;
            end
        end else if (accept) begin
            if (!pend_q.valid) pend_d = key_note;
            else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        if (complete) ptr_d = ptr_q + 5'd1;
        if (done) begin
            ptr_d   = '0;
            state_d = state_q == INIT_LABEL ? INIT_CLEAR : IDLE;
        end
        if (push) begin
            hist_d[0] = push_note;
            for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
            state_d = DRAW;
            ptr_d   = '0;
        end
    end

    // Next write is derived from next state so a fresh DRAW shows the just-pushed snapshot.
    always_comb begin
        slot = int'(ptr_d[4:1]);
        sn   = '0;
        for (int i = 0; i < HIST_DEPTH; i++) if (i == slot) sn = hist_d[i];
        h_d  = state_d == INIT_LABEL ? 8'(ORIGIN_H + int'(ptr_d)) :
               state_d == INIT_CLEAR ? 8'(ORIGIN_H + 6 + int'(ptr_d)) :
               8'(ORIGIN_H + 6 + 3 * slot + int'(ptr_d[0]));
        c_d  = state_d == INIT_LABEL ? label_char(ptr_d) :
               (state_d == INIT_CLEAR || !sn.valid) ? CHAR_SPACE :
               ptr_d[0] ? CHAR_0 + 6'(sn.octave) : letter_char(sn.letter);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_LABEL;
            ptr_q   <= '0;
            hist_q  <= '{default: '0};
            pend_q  <= '0;
            brk_q   <= 1'b0;
            drop_q  <= '0;
            en_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hist_q  <= hist_d;
            pend_q  <= pend_d;
            brk_q   <= brk_d;
            drop_q  <= drop_d;
            // A stalled write keeps its address and character until the terminal takes it.
            if (!(en_q && !term_w_ready)) begin
                en_q <= state_d != IDLE;
                h_q  <= h_d;
                v_q  <= 8'(ORIGIN_V);
                c_q  <= c_d;
            end
        end
    end

    assign term_h     = h_q;
    assign term_v     = v_q;
    assign term_char  = c_q;
    assign term_w_en  = en_q;
    assign busy       = state_q != IDLE;
    assign drop_count = drop_q;

endmodule
